// File: rtl/spin_phase_sampler_if.sv
// Control and result handshake between the spin phase sampler and the
// host/readout logic. The host side (master) requests measurements and
// consumes results; the sampler side (slave) reports status and spins.
interface spin_phase_sampler_if #(
  parameter int N = 4
) ();
  logic         start;
  logic         abort;
  logic         out_ready;
  logic         busy;
  logic         out_valid;
  logic [N-1:0] spins;

  modport master (
    output start,
    output abort,
    output out_ready,
    input  busy,
    input  out_valid,
    input  spins
  );

  modport slave (
    input  start,
    input  abort,
    input  out_ready,
    output busy,
    output out_valid,
    output spins
  );
endinterface

// File: rtl/spin_phase_sampler.sv
// Spin phase sampler: synchronizes N ring-oscillator taps and a reference
// oscillator, counts per-tap phase mismatches over a fixed window, and
// majority-decides each tap into one spin bit handed out over valid/ready.
module spin_phase_sampler #(
  parameter int N          = 4,
  parameter int WINDOW     = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   ising_rstn,
  input  logic [N-1:0]           osc_in,
  input  logic                   ref_in,
  spin_phase_sampler_if.slave    bus
);

  // Counter width holds 0..WINDOW; a counter sees at most WINDOW increments.
  localparam int CW   = $clog2(WINDOW + 1);
  // Timer must hold the larger of SETTLE_CYC-1 and WINDOW-1.
  localparam int TMAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] SETTLE_LOAD = TW'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);
  localparam logic [TW-1:0] WINDOW_LOAD = TW'(WINDOW - 1);
  // Decision threshold: a tap reads as 1 only with strictly more than half
  // of the window mismatched, so an exact tie on an even window gives 0.
  localparam logic [CW:0]   HALF        = (CW + 1)'(WINDOW / 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            decide;

  logic [N-1:0]    osc_s1, osc_s2;
  logic            ref_s1, ref_s2;
  logic [N-1:0]    mis;
  logic [CW-1:0]   cnt [N];
  logic [N-1:0]    spins_final;
  logic [N-1:0]    spins_q;

  // Two-flop synchronizers; taps and reference share the same depth so their
  // relative phase survives synchronization unchanged.
  // NOTE: non-blocking assignments make every flop sample the pre-edge value,
  // which is what turns these two statements into a two-stage chain rather
  // than a single wire-through.
  always_ff @(posedge clk or negedge ising_rstn) begin
    if (!ising_rstn) begin
      osc_s1 <= '0;
      osc_s2 <= '0;
      ref_s1 <= 1'b0;
      ref_s2 <= 1'b0;
    end else begin
      osc_s1 <= osc_in;
      osc_s2 <= osc_s1;
      ref_s1 <= ref_in;
      ref_s2 <= ref_s1;
    end
  end

  assign mis = osc_s2 ^ {N{ref_s2}};

  // State register and phase timer.
  always_ff @(posedge clk or negedge ising_rstn) begin
    if (!ising_rstn) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state, timer and decision strobe; abort overrides everything.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    decide  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (SETTLE_CYC == 0) begin
            state_d = MEASURE;
            timer_d = WINDOW_LOAD;
          end else begin
            state_d = SETTLE;
            timer_d = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d = MEASURE;
          timer_d = WINDOW_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      MEASURE: begin
        if (timer_q == '0) begin
          state_d = HOLD;
          decide  = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      timer_d = '0;
      decide  = 1'b0;
    end
  end

  // Mismatch counters: accumulate only while measuring, otherwise held at
  // zero so every new measurement starts from a clean count.
  // NOTE: this is a small array of flops, not a RAM, so resetting it is
  // cheap and keeps the post-reset state fully defined.
  always_ff @(posedge clk or negedge ising_rstn) begin
    if (!ising_rstn) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (state_q == MEASURE && !bus.abort) begin
          cnt[i] <= cnt[i] + CW'(mis[i]);
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Majority decision including the final cycle's mismatch sample.
  always_comb begin
    spins_final = '0;
    for (int i = 0; i < N; i++) begin
      spins_final[i] = (({1'b0, cnt[i]} + (CW + 1)'(mis[i])) > HALF);
    end
  end

  // Result register, written only on the MEASURE->HOLD transition.
  always_ff @(posedge clk or negedge ising_rstn) begin
    if (!ising_rstn) begin
      spins_q <= '0;
    end else if (decide) begin
      spins_q <= spins_final;
    end
  end

  assign bus.busy      = (state_q == SETTLE) || (state_q == MEASURE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.spins     = spins_q;

endmodule

// File: tb/tb_spin_phase_sampler.sv
// Self-checking bench for spin_phase_sampler: directed phase patterns,
// latency, backpressure, abort and async reset, plus biased random taps
// checked against a window-count model built from the recorded input history.
module tb_spin_phase_sampler;
  localparam int N = 4;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] osc;
  logic         ref_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spin_phase_sampler_if #(.N(N)) bus ();

  spin_phase_sampler #(.N(N), .WINDOW(W), .SETTLE_CYC(S)) dut (
    .clk        (clk),
    .ising_rstn (rstn),
    .osc_in     (osc),
    .ref_in     (ref_i),
    .bus        (bus)
  );

  // Input history as seen at each rising edge, indexed by edge number.
  int           edge_cnt = 0;
  logic [N-1:0] h_osc [0:8191];
  logic         h_ref [0:8191];

  always @(posedge clk) begin
    h_osc[edge_cnt] <= osc;
    h_ref[edge_cnt] <= ref_i;
    edge_cnt        <= edge_cnt + 1;
  end

  // Stimulus source: 0 = directed phase pattern, 1 = biased random taps.
  int   mode = 1;
  int   ph   = 0;
  logic prev_ref = 1'b0;
  int   bias [N];

  // Reference model: a start sampled at edge e0 measures on edges
  // e0+S+1 .. e0+S+W; the two-flop synchronizers mean each of those edges
  // sees the inputs present two edges earlier.
  function automatic logic [N-1:0] model(int e0);
    logic [N-1:0] res;
    int c;
    res = '0;
    for (int i = 0; i < N; i++) begin
      c = 0;
      for (int t = e0 + S + 1; t <= e0 + S + W; t++) begin
        c += int'(h_osc[t-2][i] ^ h_ref[t-2]);
      end
      res[i] = (c > W / 2);
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and update the oscillator inputs there.
  task automatic cycle();
    logic r;
    @(negedge clk);
    ph++;
    if (mode == 0) begin
      prev_ref = ref_i;
      ref_i    = ph[1];
      osc      = {1'b0, prev_ref, ~ref_i, ref_i};
    end else begin
      r     = 1'($urandom_range(0, 1));
      ref_i = r;
      for (int i = 0; i < N; i++) begin
        osc[i] = r ^ ($urandom_range(0, 99) < bias[i]);
      end
    end
  endtask

  task automatic pulse_start(output int e0);
    bus.start = 1'b1;
    e0        = edge_cnt;
    cycle();
    bus.start = 1'b0;
  endtask

  // Bounded wait for out_valid; an expired bound shows up as a latency miss.
  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      cycle();
      n++;
    end
  endtask

  task automatic randomize_bias();
    for (int i = 0; i < N; i++) bias[i] = $urandom_range(0, 100);
  endtask

  initial begin
    int e0;
    logic [N-1:0] exp_spins;

    rstn          = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    osc           = '0;
    ref_i         = 1'b0;
    for (int i = 0; i < N; i++) bias[i] = 50;

    // Reset held with toggling inputs, including start.
    for (int k = 0; k < 5; k++) begin
      bus.start = 1'(k & 1);
      cycle();
    end
    bus.start = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_spins", bus.spins, 0);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    check("idle_busy", bus.busy, 0);
    check("idle_valid", bus.out_valid, 0);

    // Directed phase pattern with per-cycle latency checks.
    mode = 0;
    for (int k = 0; k < 4; k++) cycle();
    pulse_start(e0);
    for (int k = 0; k < S + W; k++) begin
      check($sformatf("lat_busy_%0d", k), bus.busy, 1);
      check($sformatf("lat_novalid_%0d", k), bus.out_valid, 0);
      if (k < S + W - 1) cycle();
    end
    cycle();
    check("lat_valid", bus.out_valid, 1);
    check("lat_busy_done", bus.busy, 0);
    check("lat_edges", edge_cnt - 1 - e0, S + W);
    check("pattern_spins", bus.spins, 4'b0010);
    check("pattern_model", bus.spins, model(e0));

    // Backpressure: result held, a start in HOLD is ignored.
    for (int k = 0; k < 10; k++) begin
      bus.start = (k == 5);
      cycle();
      check($sformatf("bp_valid_%0d", k), bus.out_valid, 1);
      check($sformatf("bp_spins_%0d", k), bus.spins, 4'b0010);
    end
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_busy", bus.busy, 0);
    cycle();
    check("exit_start_ignored", bus.busy, 0);

    // Abort in the eighth MEASURE cycle.
    mode = 1;
    randomize_bias();
    pulse_start(e0);
    while (edge_cnt - 1 < e0 + S + 7) cycle();
    check("abort_pre_busy", bus.busy, 1);
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_valid", bus.out_valid, 0);
    check("abort_spins_kept", bus.spins, 4'b0010);
    for (int k = 0; k < 25; k++) cycle();
    check("abort_no_valid", bus.out_valid, 0);
    pulse_start(e0);
    wait_valid();
    check("post_abort_lat", edge_cnt - 1 - e0, S + W);
    check("post_abort_spins", bus.spins, model(e0));
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;

    // Biased random measurements against the window model.
    for (int r = 0; r < 8; r++) begin
      randomize_bias();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) cycle();
      pulse_start(e0);
      wait_valid();
      exp_spins = model(e0);
      check($sformatf("rand_lat_%0d", r), edge_cnt - 1 - e0, S + W);
      check($sformatf("rand_spins_%0d", r), bus.spins, exp_spins);
      bus.out_ready = 1'b1;
      cycle();
      bus.out_ready = 1'b0;
      check($sformatf("rand_release_%0d", r), bus.out_valid, 0);
    end

    // Async reset in the middle of MEASURE, between clock edges.
    randomize_bias();
    for (int k = 0; k < 8; k++) bias[k % N] = (k < N) ? 100 : bias[k % N];
    pulse_start(e0);
    wait_valid();
    check("pre_arst_spins", bus.spins, 4'b1111);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    pulse_start(e0);
    for (int k = 0; k < S + 6; k++) cycle();
    check("arst_pre_busy", bus.busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_valid", bus.out_valid, 0);
    check("arst_spins", bus.spins, 0);
    cycle();
    rstn = 1'b1;
    mode = 0;
    cycle();
    check("arst_idle", bus.busy, 0);
    pulse_start(e0);
    wait_valid();
    check("rerun_lat", edge_cnt - 1 - e0, S + W);
    check("rerun_spins", bus.spins, 4'b0010);
    check("rerun_model", bus.spins, model(e0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
